// File: rtl/decimal_to_binary_encoder.sv
// Registered one-hot decimal (10 lines) to 4-bit binary encoder.
// Zero-hot and multi-hot inputs are flagged; multi-hot resolves by HIGH_PRIORITY.
module decimal_to_binary_encoder #(
  parameter int unsigned HIGH_PRIORITY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [9:0] Decimal,
  output logic [3:0] Binary,
  output logic       valid_out,
  output logic       no_hot,
  output logic       multi_hot
);

  logic [3:0] binary_d;
  logic       no_hot_d;
  logic       multi_hot_d;

  logic [3:0] binary_q;
  logic       valid_q;
  logic       no_hot_q;
  logic       multi_hot_q;

  // Priority encoder: the last match found in scan order wins.
  always_comb begin
    binary_d = 4'd0;
    if (HIGH_PRIORITY != 0) begin
      for (int i = 0; i < 10; i++) begin
        if (Decimal[i]) binary_d = 4'(i);
      end
    end else begin
      for (int i = 9; i >= 0; i--) begin
        if (Decimal[i]) binary_d = 4'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  always_comb begin
    no_hot_d    = (Decimal == 10'd0);
    multi_hot_d = |(Decimal & (Decimal - 10'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      binary_q    <= 4'd0;
      valid_q     <= 1'b0;
      no_hot_q    <= 1'b0;
      multi_hot_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        binary_q    <= binary_d;
        no_hot_q    <= no_hot_d;
        multi_hot_q <= multi_hot_d;
      end
    end
  end

  assign Binary    = binary_q;
  assign valid_out = valid_q;
  assign no_hot    = no_hot_q;
  assign multi_hot = multi_hot_q;

endmodule

// File: tb/tb_decimal_to_binary_encoder.sv
// Bench for decimal_to_binary_encoder: both priority settings side by side,
// table vectors, hand sequences and random stimulus against a reference model.
module tb_decimal_to_binary_encoder;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [9:0] Decimal;

  logic [3:0] bin_hi, bin_lo;
  logic       vo_hi, vo_lo, nh_hi, nh_lo, mh_hi, mh_lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_hi, m_lo;
  logic       m_vo, m_nh, m_mh;

  decimal_to_binary_encoder #(.HIGH_PRIORITY(1)) u_hi (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .Decimal  (Decimal),
    .Binary   (bin_hi),
    .valid_out(vo_hi),
    .no_hot   (nh_hi),
    .multi_hot(mh_hi)
  );

  decimal_to_binary_encoder #(.HIGH_PRIORITY(0)) u_lo (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .Decimal  (Decimal),
    .Binary   (bin_lo),
    .valid_out(vo_lo),
    .no_hot   (nh_lo),
    .multi_hot(mh_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] dec;
    logic [3:0] exp_hi;
    logic [3:0] exp_lo;
    logic       exp_nh;
    logic       exp_mh;
  } vec_t;

  vec_t vecs[$];

  function automatic int highest_index(int d);
    int n = 0;
    if (d == 0) return 0;
    while (d > 1) begin
      d = d / 2;
      n++;
    end
    return n;
  endfunction

  function automatic int lowest_index(int d);
    int n = 0;
    if (d == 0) return 0;
    while (d % 2 == 0) begin
      d = d / 2;
      n++;
    end
    return n;
  endfunction

  // Apply one cycle of stimulus and advance the model; outputs are sampled 1ns after the edge.
  task automatic drive(input logic r, input logic v, input logic [9:0] d);
    rst      = r;
    valid_in = v;
    Decimal  = d;
    @(posedge clk);
    if (r) begin
      m_hi = 4'd0; m_lo = 4'd0; m_vo = 1'b0; m_nh = 1'b0; m_mh = 1'b0;
    end else begin
      m_vo = v;
      if (v) begin
        m_hi = 4'(highest_index(int'(d)));
        m_lo = 4'(lowest_index(int'(d)));
        m_nh = (d == 10'd0);
        m_mh = ($countones(d) > 1);
      end
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] ehi, input logic [3:0] elo,
                     input logic evo, input logic enh, input logic emh);
    n_checks++;
    if ({bin_hi, vo_hi, nh_hi, mh_hi} !== {ehi, evo, enh, emh}) begin
      n_fail++;
      $display("FAIL %s [HIGH_PRIORITY=1]: got bin=%0d vo=%b nh=%b mh=%b, want bin=%0d vo=%b nh=%b mh=%b",
               name, bin_hi, vo_hi, nh_hi, mh_hi, ehi, evo, enh, emh);
    end
    n_checks++;
    if ({bin_lo, vo_lo, nh_lo, mh_lo} !== {elo, evo, enh, emh}) begin
      n_fail++;
      $display("FAIL %s [HIGH_PRIORITY=0]: got bin=%0d vo=%b nh=%b mh=%b, want bin=%0d vo=%b nh=%b mh=%b",
               name, bin_lo, vo_lo, nh_lo, mh_lo, elo, evo, enh, emh);
    end
  endtask

  initial begin
    int         wide;
    logic [9:0] trunc;
    vec_t       v;

    rst = 1'b1; valid_in = 1'b0; Decimal = '0;
    m_hi = 4'd0; m_lo = 4'd0; m_vo = 1'b0; m_nh = 1'b0; m_mh = 1'b0;

    // Walking one-hot, zero, truncated 1024, multi-hot
    for (int i = 0; i < 10; i++) begin
      v.dec = 10'd1 << i; v.exp_hi = 4'(i); v.exp_lo = 4'(i); v.exp_nh = 1'b0; v.exp_mh = 1'b0;
      vecs.push_back(v);
    end
    v.dec = 10'd0; v.exp_hi = 4'd0; v.exp_lo = 4'd0; v.exp_nh = 1'b1; v.exp_mh = 1'b0;
    vecs.push_back(v);
    wide  = 1024;
    trunc = wide[9:0];
    v.dec = trunc;
    vecs.push_back(v);
    v.dec = 10'b1000000101; v.exp_hi = 4'd9; v.exp_lo = 4'd0; v.exp_nh = 1'b0; v.exp_mh = 1'b1;
    vecs.push_back(v);
    v.dec = 10'b0000110000; v.exp_hi = 4'd5; v.exp_lo = 4'd4;
    vecs.push_back(v);
    v.dec = 10'b1111111111; v.exp_hi = 4'd9; v.exp_lo = 4'd0;
    vecs.push_back(v);
    v.dec = 10'b0100000010; v.exp_hi = 4'd8; v.exp_lo = 4'd1;
    vecs.push_back(v);

    drive(1'b1, 1'b1, 10'h3FF);
    drive(1'b1, 1'b0, 10'h000);
    chk("reset_state", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      drive(1'b0, 1'b1, vecs[k].dec);
      chk($sformatf("vec%0d_dec%0d", k, vecs[k].dec), vecs[k].exp_hi, vecs[k].exp_lo, 1'b1,
          vecs[k].exp_nh, vecs[k].exp_mh);
    end

    // Hold on idle
    drive(1'b0, 1'b1, 10'd64);
    chk("hold_load", 4'd6, 4'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 10'd8);
      chk($sformatf("hold_idle%0d", i), 4'd6, 4'd6, 1'b0, 1'b0, 1'b0);
    end

    // Flags also hold across idle
    drive(1'b0, 1'b1, 10'd0);
    drive(1'b0, 1'b0, 10'b0000000011);
    chk("hold_flags", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Reset mid-stream
    drive(1'b0, 1'b1, 10'd1);
    chk("stream_1", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 10'd2);
    chk("stream_2", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 10'd4);
    chk("stream_rst", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 10'd16);
    chk("stream_after_rst", 4'd4, 4'd4, 1'b1, 1'b0, 1'b0);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      logic       r, vv;
      logic [9:0] d;
      int         mode;
      r    = ($urandom_range(0, 19) == 0);
      vv   = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       d = 10'd1 << $urandom_range(0, 9);
        1:       d = 10'd0;
        default: d = 10'($urandom);
      endcase
      drive(r, vv, d);
      chk($sformatf("rand%0d_dec%0d", i, d), m_hi, m_lo, m_vo, m_nh, m_mh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
